// File: rtl/binning_nxn.sv
// NxN pixel binning (1x1 / 2x2 / 4x4) with a fixed 3-cycle pipeline.
// Define BINNING_NXN_ROUND_EN to round half up instead of truncating the average.
module binning_nxn #(
   parameter int DATA_WIDTH    = 8,
   parameter int CH_COUNT      = 1,
   parameter int LINE_SIZE_MAX = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           bypass,
   input  logic [1:0]                     bin_mode,
   input  logic [CH_COUNT*DATA_WIDTH-1:0] di_i,
   input  logic                           de_i,
   input  logic                           hs_i,
   input  logic                           vs_i,
   output logic [CH_COUNT*DATA_WIDTH-1:0] do_o,
   output logic                           de_o,
   output logic                           hs_o,
   output logic                           vs_o
);

   localparam int HW       = DATA_WIDTH + 2;
   localparam int TW       = DATA_WIDTH + 4;
   localparam int CW       = $clog2(LINE_SIZE_MAX + 1);
   localparam int LB_DEPTH = LINE_SIZE_MAX / 2;
   localparam int AW       = $clog2(LB_DEPTH);

   logic          vs_d, hs_d, frame_q, frame_cur, vs_rise, hs_rise;
   logic [1:0]    nlog_q, nlog_new, nlog_cur, mask;
   logic [CW-1:0] col_cnt;
   logic [1:0]    row_cnt;
   logic          col_ok, pix_ok, bin_last;
   logic [2:0]    hs_pipe, vs_pipe;

   logic [CH_COUNT*HW-1:0] hsum_nxt, s1_hsum;
   logic                   s1_done, s1_rfirst, s1_rlast;
   logic [AW-1:0]          s1_bcol;
   logic [1:0]             s1_nlog;

   logic [CH_COUNT*TW-1:0] lb [LB_DEPTH];
   logic [CH_COUNT*TW-1:0] lb_rd, total, s2_total;
   logic                   s2_emit;
   logic [1:0]             s2_nlog;

   logic [2:0]                     sh;
   logic [TW-1:0]                  rnd, rsum;
   logic [CH_COUNT*DATA_WIDTH-1:0] binned;

   // Mode and frame-valid take effect in the same cycle as the vs_i rising edge.
   always_comb begin
      vs_rise   = vs_i & ~vs_d;
      hs_rise   = hs_i & ~hs_d;
      frame_cur = vs_rise | (frame_q & vs_i);
      if (bypass || bin_mode == 2'd0) nlog_new = 2'd0;
      else if (bin_mode == 2'd1)      nlog_new = 2'd1;
      else                            nlog_new = 2'd2;
      nlog_cur = vs_rise ? nlog_new : nlog_q;
      case (nlog_cur)
         2'd0:    mask = 2'b00;
         2'd1:    mask = 2'b01;
         default: mask = 2'b11;
      endcase
      col_ok   = col_cnt < CW'(LINE_SIZE_MAX);
      pix_ok   = de_i & vs_i & ~hs_i & frame_cur & col_ok;
      bin_last = (col_cnt[1:0] & mask) == mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d    <= vs_i;
         hs_d    <= hs_i;
         frame_q <= 1'b0;
         nlog_q  <= 2'd0;
         col_cnt <= '0;
         row_cnt <= '0;
      end else begin
         vs_d    <= vs_i;
         hs_d    <= hs_i;
         frame_q <= frame_cur;
         nlog_q  <= nlog_cur;
         if (hs_i || !vs_i)
            col_cnt <= '0;
         else if (de_i && col_cnt != CW'(LINE_SIZE_MAX))
            col_cnt <= col_cnt + CW'(1);
         if (!vs_i)
            row_cnt <= '0;
         else if (hs_rise)
            row_cnt <= row_cnt + 2'd1;
      end
   end

   // Stage 1: horizontal accumulation; in 1x1 mode the input passes every cycle.
   always_comb begin
      hsum_nxt = '0;
      for (int k = 0; k < CH_COUNT; k++)
         hsum_nxt[k*HW +: HW] = ((nlog_cur == 2'd0 || (col_cnt[1:0] & mask) == 2'b00)
                                 ? HW'(0) : s1_hsum[k*HW +: HW])
                                + HW'(di_i[k*DATA_WIDTH +: DATA_WIDTH]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hsum   <= '0;
         s1_done   <= 1'b0;
         s1_rfirst <= 1'b0;
         s1_rlast  <= 1'b0;
         s1_bcol   <= '0;
         s1_nlog   <= 2'd0;
      end else begin
         if (nlog_cur == 2'd0 || pix_ok)
            s1_hsum <= hsum_nxt;
         s1_done   <= pix_ok & bin_last;
         s1_rfirst <= (row_cnt & mask) == 2'b00;
         s1_rlast  <= (row_cnt & mask) == mask;
         s1_bcol   <= AW'(col_cnt >> nlog_cur);
         s1_nlog   <= nlog_cur;
      end
   end

   // Stage 2: vertical accumulation; the first row of a group overwrites stale data.
   always_comb begin
      lb_rd = lb[s1_bcol];
      total = '0;
      for (int k = 0; k < CH_COUNT; k++)
         total[k*TW +: TW] = (s1_rfirst ? TW'(0) : lb_rd[k*TW +: TW])
                             + TW'(s1_hsum[k*HW +: HW]);
   end

   always_ff @(posedge clk) begin
      if (s1_done && s1_nlog != 2'd0)
         lb[s1_bcol] <= total;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_total <= '0;
         s2_emit  <= 1'b0;
         s2_nlog  <= 2'd0;
      end else begin
         s2_total <= total;
         s2_emit  <= s1_done & s1_rlast;
         s2_nlog  <= s1_nlog;
      end
   end

   // Stage 3: divide by N*N.
   always_comb begin
      sh = {s2_nlog, 1'b0};
`ifdef BINNING_NXN_ROUND_EN
      rnd = (TW'(1) << sh) >> 1;
`else
      rnd = '0;
`endif
      rsum   = '0;
      binned = '0;
      for (int k = 0; k < CH_COUNT; k++) begin
         rsum = s2_total[k*TW +: TW] + rnd;
         binned[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rsum >> sh);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         do_o    <= '0;
         de_o    <= 1'b0;
         hs_pipe <= '0;
         vs_pipe <= '0;
      end else begin
         if (s2_emit || s2_nlog == 2'd0)
            do_o <= binned;
         de_o    <= s2_emit;
         hs_pipe <= {hs_pipe[1:0], hs_i};
         vs_pipe <= {vs_pipe[1:0], vs_i};
      end
   end

   assign hs_o = hs_pipe[2];
   assign vs_o = vs_pipe[2];

endmodule

// File: tb/tb_binning_nxn.sv
// Self-checking bench for binning_nxn: directed frames plus randomized frames
// checked against a per-bin averaging model of the image.
module tb_binning_nxn;

   localparam int DW   = 8;
   localparam int CH   = 3;
   localparam int LMAX = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               bypass = 1'b0;
   logic [1:0]         bin_mode = 2'd1;
   logic [CH*DW-1:0]   di_i = '0;
   logic               de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0;
   logic [CH*DW-1:0]   do_o;
   logic               de_o, hs_o, vs_o;

   binning_nxn #(.DATA_WIDTH(DW), .CH_COUNT(CH), .LINE_SIZE_MAX(LMAX)) dut (
      .clk(clk), .rst(rst), .bypass(bypass), .bin_mode(bin_mode),
      .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
      .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o));

   always #5 clk = ~clk;

   typedef struct {
      logic [CH*DW-1:0] val;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0, cyc = 0, out_cnt = 0;
   bit   mon_en = 1'b0;
   logic hist_hs [64];
   logic hist_vs [64];
   int   img [CH][12][24];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int eff_n(input logic byp, input logic [1:0] m);
      if (byp || m == 2'd0) return 1;
      if (m == 2'd1) return 2;
      return 4;
   endfunction

   // Average of one n x n bin, computed straight from the image.
   function automatic logic [CH*DW-1:0] bin_val(input int bx, input int by, input int n);
      logic [CH*DW-1:0] r;
      int s;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         s = 0;
         for (int dy = 0; dy < n; dy++)
            for (int dx = 0; dx < n; dx++)
               s += img[c][by*n+dy][bx*n+dx];
`ifdef BINNING_NXN_ROUND_EN
         s += (n * n) / 2;
`endif
         r[c*DW +: DW] = DW'(s / (n * n));
      end
      return r;
   endfunction

   function automatic logic [CH*DW-1:0] pix(input int x, input int y);
      logic [CH*DW-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(img[c][y][x]);
      return r;
   endfunction

   task automatic fill_const(input int r, input int g, input int b);
      for (int y = 0; y < 12; y++)
         for (int x = 0; x < 24; x++) begin
            img[0][y][x] = r; img[1][y][x] = g; img[2][y][x] = b;
         end
   endtask

   task automatic fill_x();
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < 12; y++)
            for (int x = 0; x < 24; x++) img[c][y][x] = x;
   endtask

   task automatic fill_rand();
      for (int c = 0; c < CH; c++)
         for (int y = 0; y < 12; y++)
            for (int x = 0; x < 24; x++) img[c][y][x] = int'($urandom_range(0, 255));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [CH*DW-1:0] got, input logic [CH*DW-1:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_do"}, do_o, '0);
      check({tag, "_de"}, {{(CH*DW-1){1'b0}}, de_o}, '0);
      check({tag, "_hs"}, {{(CH*DW-1){1'b0}}, hs_o}, '0);
      check({tag, "_vs"}, {{(CH*DW-1){1'b0}}, vs_o}, '0);
   endtask

   task automatic reset_mid();
      mon_en = 1'b0;
      de_i   = 1'b0;
      rst    = 1'b1;
      step();
      check_zero_outputs("rst_mid");
      rst = 1'b0;
      repeat (4) step();
      exp_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic drive_frame(input int w, input int h, input int maxgap,
                              input int chg_row, input logic [1:0] chg_mode, input int rst_row);
      int   n;
      bit   chk;
      exp_t e;
      chk  = 1'b1;
      n    = eff_n(bypass, bin_mode);
      vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0;
      step(); step();
      for (int y = 0; y < h; y++) begin
         if (y == chg_row) bin_mode = chg_mode;
         hs_i = 1'b0;
         for (int x = 0; x < w; x++) begin
            repeat ($urandom_range(0, maxgap)) begin de_i = 1'b0; step(); end
            if (y == rst_row && x == w / 2) begin
               reset_mid();
               chk = 1'b0;
            end
            di_i = pix(x, y);
            de_i = 1'b1;
            if (chk && x < LMAX && (x + 1) % n == 0 && (y + 1) % n == 0) begin
               e.val = bin_val(x / n, y / n, n);
               e.cyc = cyc + 3;
               exp_q.push_back(e);
            end
            step();
         end
         de_i = 1'b0; hs_i = 1'b1;
         step(); step();
      end
      vs_i = 1'b0;
      step(); step(); step();
   endtask

   // Output monitor: hs/vs delay, de_o timing and binned value per expected bin.
   always @(negedge clk) begin
      hist_hs[cyc % 64] = hs_i;
      hist_vs[cyc % 64] = vs_i;
      if (mon_en) begin
         checks++;
         assert (hs_o === hist_hs[(cyc - 3) % 64]) else begin
            errors++; $error("FAIL hs_delay cyc %0d got %b expected %b", cyc, hs_o, hist_hs[(cyc-3)%64]);
         end
         checks++;
         assert (vs_o === hist_vs[(cyc - 3) % 64]) else begin
            errors++; $error("FAIL vs_delay cyc %0d got %b expected %b", cyc, vs_o, hist_vs[(cyc-3)%64]);
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++; errors++;
            $error("FAIL missed_de got none expected de_o at cyc %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (de_o) begin
            out_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++; $error("FAIL unexpected_de got de_o at cyc %0d expected none", cyc);
            end
            if (exp_q.size() > 0) begin
               checks++;
               assert (cyc === exp_q[0].cyc) else begin
                  errors++; $error("FAIL de_timing got cyc %0d expected cyc %0d", cyc, exp_q[0].cyc);
               end
               checks++;
               assert (do_o === exp_q[0].val) else begin
                  errors++; $error("FAIL do_value got %0h expected %0h", do_o, exp_q[0].val);
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [CH*DW-1:0] want;
      int n, w, h;

      repeat (3) step();
      check_zero_outputs("rst_init");
      rst = 1'b0;
      repeat (4) step();
      mon_en = 1'b1;

      // 8x8 flat 100, 2x2, back-to-back pixels
      bypass = 1'b0; bin_mode = 2'd1; fill_const(100, 100, 100);
      out_cnt = 0; drive_frame(8, 8, 0, -1, 2'd0, -1);
      check("flat_count", CH*DW'(out_cnt), CH*DW'(16));
      check("flat_value", do_o, {3{8'd100}});

      // single 2x2 bin {1,2,2,2}
      fill_const(2, 2, 2); img[0][0][0] = 1; img[1][0][0] = 1; img[2][0][0] = 1;
      drive_frame(2, 2, 1, -1, 2'd0, -1);
`ifdef BINNING_NXN_ROUND_EN
      want = {3{8'd2}};
`else
      want = {3{8'd1}};
`endif
      check("round_bin", do_o, want);

      // 10x9 ramp, 4x4: trailing columns and row dropped
      bin_mode = 2'd2; fill_x();
      out_cnt = 0; drive_frame(10, 9, 0, -1, 2'd0, -1);
      check("ramp_count", CH*DW'(out_cnt), CH*DW'(4));
`ifdef BINNING_NXN_ROUND_EN
      want = {3{8'd6}};
`else
      want = {3{8'd5}};
`endif
      check("ramp_last", do_o, want);

      // mode change mid-frame takes effect next frame
      bin_mode = 2'd1; fill_rand();
      out_cnt = 0; drive_frame(8, 6, 1, 2, 2'd2, -1);
      check("chg_count_2x2", CH*DW'(out_cnt), CH*DW'(12));
      fill_rand();
      out_cnt = 0; drive_frame(8, 8, 1, -1, 2'd0, -1);
      check("chg_count_4x4", CH*DW'(out_cnt), CH*DW'(4));

      // three channels stay independent
      bin_mode = 2'd1; fill_const(255, 0, 16);
      out_cnt = 0; drive_frame(6, 4, 2, -1, 2'd0, -1);
      check("rgb_count", CH*DW'(out_cnt), CH*DW'(6));
      check("rgb_value", do_o, {8'd16, 8'd0, 8'd255});

      // columns past LINE_SIZE_MAX ignored
      fill_rand();
      out_cnt = 0; drive_frame(20, 2, 0, -1, 2'd0, -1);
      check("linemax_count", CH*DW'(out_cnt), CH*DW'(8));

      // bypass overrides bin_mode
      bypass = 1'b1; bin_mode = 2'd2; fill_rand();
      out_cnt = 0; drive_frame(5, 3, 2, -1, 2'd0, -1);
      check("bypass_count", CH*DW'(out_cnt), CH*DW'(15));
      bypass = 1'b0;

      // reserved mode behaves as 4x4
      bin_mode = 2'd3; fill_rand();
      out_cnt = 0; drive_frame(8, 4, 1, -1, 2'd0, -1);
      check("mode3_count", CH*DW'(out_cnt), CH*DW'(2));

      // reset mid-line, remainder of frame ignored, next frame clean
      bin_mode = 2'd1; fill_rand();
      drive_frame(8, 6, 1, -1, 2'd0, 3);
      check("rst_mode_n1", CH*DW'(eff_n(1'b0, 2'd1)), CH*DW'(2));
      fill_rand();
      out_cnt = 0; drive_frame(6, 4, 1, -1, 2'd0, -1);
      check("post_rst_count", CH*DW'(out_cnt), CH*DW'(6));

      // randomized frames
      for (int i = 0; i < 14; i++) begin
         bypass   = ($urandom_range(0, 4) == 0);
         bin_mode = 2'($urandom_range(0, 3));
         w = int'($urandom_range(1, 20));
         h = int'($urandom_range(1, 10));
         n = eff_n(bypass, bin_mode);
         fill_rand();
         out_cnt = 0;
         drive_frame(w, h, int'($urandom_range(0, 2)), -1, 2'd0, -1);
         check("rand_count", CH*DW'(out_cnt),
               CH*DW'(((w < LMAX ? w : LMAX) / n) * (h / n)));
      end

      repeat (5) step();
      checks++;
      assert (exp_q.size() === 0) else begin
         errors++; $error("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
